// File: rtl/jtframe_slot_pkg.sv
// Shared definitions for the 4-slot SDRAM read arbiter: slot count,
// FSM state encoding and the round-robin selection helper.
package jtframe_slot_pkg;

  localparam int SLOTS   = 4;
  localparam int SLOT_IW = 2;   // bits needed to index a slot

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ACK  = 2'd1,
    WAIT_DATA = 2'd2
  } state_t;

  // Pick the first requesting slot after 'last', wrapping modulo SLOTS.
  // Offsets are scanned from farthest to nearest so the nearest requester
  // overwrites the result; offset SLOTS is 'last' itself (lowest priority).
  function automatic logic [SLOT_IW-1:0] rr_pick(
    input logic [SLOTS-1:0]   req,
    input logic [SLOT_IW-1:0] last
  );
    logic [SLOT_IW-1:0] idx;
    rr_pick = last;
    for (int k = SLOTS; k >= 1; k--) begin
      idx = last + SLOT_IW'(k);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/jtframe_slot_cache.sv
// One-entry read cache for a single slot: tag, data word and valid flag,
// plus the combinational hit compare against the slot's current address.
module jtframe_slot_cache
  import jtframe_slot_pkg::*;
#(
  parameter int AW = 22
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cs,
  input  logic [AW-1:0] addr,
  input  logic          clr,
  input  logic          we,
  input  logic [AW-1:0] fill_addr,
  input  logic [31:0]   fill_data,
  output logic          hit,
  output logic [31:0]   dout
);

  logic [AW-1:0] tag;
  logic          valid;

  // Fill the entry on a completed read; clr (download) wins over the fill
  // for the valid flag so a word fetched during a download never hits.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: tag and data are reset too, so slot_dout reads zero after
      // reset instead of whatever the flops powered up with.
      tag   <= '0;
      dout  <= '0;
      valid <= 1'b0;
    end else begin
      // NOTE: state uses non-blocking assignments so every flop samples
      // pre-edge values regardless of statement order.
      if (we) begin
        tag  <= fill_addr;
        dout <= fill_data;
      end
      if (clr)     valid <= 1'b0;
      else if (we) valid <= 1'b1;
    end
  end

  // Hit only when the slot is asking for exactly the cached address.
  assign hit = cs & valid & (addr == tag);

endmodule

// File: rtl/jtframe_slot_arb.sv
// Four-slot SDRAM read arbiter. Each slot has a one-word cache; misses are
// served one at a time in round-robin order through a req/ack/data_rdy
// handshake with the SDRAM controller.
module jtframe_slot_arb
  import jtframe_slot_pkg::*;
#(
  parameter int AW = 22
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                downloading,
  input  logic                loop_rst,
  input  logic [SLOTS-1:0]    slot_cs,
  input  logic [SLOTS*AW-1:0] slot_addr,
  output logic [SLOTS-1:0]    slot_ok,
  output logic [SLOTS*32-1:0] slot_dout,
  output logic                sdram_req,
  input  logic                sdram_ack,
  output logic [AW-1:0]       sdram_addr,
  input  logic                data_rdy,
  input  logic [31:0]         data_read,
  output logic                refresh_en
);

  state_t             state;
  logic [SLOT_IW-1:0] grant;       // slot owning the transaction in flight
  logic [SLOT_IW-1:0] last_grant;  // slot served most recently
  logic [SLOT_IW-1:0] next_grant;
  logic [AW-1:0]      next_addr;
  logic [SLOTS-1:0]   hit;
  logic [SLOTS-1:0]   pend;
  logic               fill_we;
  logic               start;
  logic [AW-1:0]      addr_arr [SLOTS];

  // Per-slot caches. Fills are written under the latched request address,
  // not the slot's live address, so a moved slot simply misses again.
  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    assign addr_arr[i] = slot_addr[i*AW +: AW];

    jtframe_slot_cache #(.AW(AW)) u_cache (
      .clk       (clk),
      .rst       (rst),
      .cs        (slot_cs[i]),
      .addr      (addr_arr[i]),
      .clr       (downloading),
      .we        (fill_we && (grant == SLOT_IW'(i))),
      .fill_addr (sdram_addr),
      .fill_data (data_read),
      .hit       (hit[i]),
      .dout      (slot_dout[i*32 +: 32])
    );
  end

  assign slot_ok = hit;
  assign pend    = slot_cs & ~hit;

  // Data is accepted in WAIT_DATA, or in WAIT_ACK when the controller
  // acknowledges and returns data in the same cycle.
  assign fill_we = data_rdy &
                   ((state == WAIT_DATA) | ((state == WAIT_ACK) & sdram_ack));

  // A new transaction starts only from IDLE and never during a download
  // or the SDRAM init loop.
  assign start = (state == IDLE) & (|pend) & ~downloading & ~loop_rst;

  // Round-robin choice of the next slot and its address.
  always_comb begin
    next_grant = rr_pick(pend, last_grant);
    next_addr  = addr_arr[next_grant];
  end

  // Refresh may run whenever no read is in flight and nobody is waiting.
  assign refresh_en = (state == IDLE) & ~(|pend);

  // Request/ack/data handshake with registered sdram_req and sdram_addr.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
      grant      <= '0;
      last_grant <= SLOT_IW'(SLOTS - 1);
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            grant      <= next_grant;
            sdram_addr <= next_addr;
            sdram_req  <= 1'b1;
            state      <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (sdram_ack) begin
            sdram_req <= 1'b0;
            if (data_rdy) begin
              last_grant <= grant;
              state      <= IDLE;
            end else begin
              state <= WAIT_DATA;
            end
          end
        end
        WAIT_DATA: begin
          if (data_rdy) begin
            last_grant <= grant;
            state      <= IDLE;
          end
        end
        default: begin
          sdram_req <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtframe_slot_arb.sv
// Self-checking bench for jtframe_slot_arb: acts as the SDRAM controller
// and keeps a slot-level cache/round-robin model to predict outputs.
module tb_jtframe_slot_arb;

  localparam int AW = 22;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            downloading = 1'b0;
  logic            loop_rst = 1'b0;
  logic [3:0]      slot_cs = '0;
  logic [4*AW-1:0] slot_addr = '0;
  logic [3:0]      slot_ok;
  logic [127:0]    slot_dout;
  logic            sdram_req;
  logic            sdram_ack = 1'b0;
  logic [AW-1:0]   sdram_addr;
  logic            data_rdy = 1'b0;
  logic [31:0]     data_read = '0;
  logic            refresh_en;

  int checks = 0;
  int errors = 0;

  // Reference model: one cached word per slot and the last-served slot.
  logic [AW-1:0] m_tag   [4];
  logic [31:0]   m_data  [4];
  bit            m_valid [4];
  int            m_last;

  jtframe_slot_arb #(.AW(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .downloading (downloading),
    .loop_rst    (loop_rst),
    .slot_cs     (slot_cs),
    .slot_addr   (slot_addr),
    .slot_ok     (slot_ok),
    .slot_dout   (slot_dout),
    .sdram_req   (sdram_req),
    .sdram_ack   (sdram_ack),
    .sdram_addr  (sdram_addr),
    .data_rdy    (data_rdy),
    .data_read   (data_read),
    .refresh_en  (refresh_en)
  );

  always #5 clk = ~clk;

  function automatic logic [AW-1:0] a_of(input int i);
    return slot_addr[i*AW +: AW];
  endfunction

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    slot_addr[i*AW +: AW] = a;
  endtask

  function automatic logic [3:0] exp_ok();
    logic [3:0] r;
    for (int i = 0; i < 4; i++)
      r[i] = slot_cs[i] && m_valid[i] && (a_of(i) == m_tag[i]);
    return r;
  endfunction

  function automatic logic [3:0] exp_pend();
    return slot_cs & ~exp_ok();
  endfunction

  // Next slot to serve: walk forward from the last served slot.
  function automatic int rr_next(input logic [3:0] p);
    for (int k = 1; k <= 4; k++) begin
      int idx;
      idx = (m_last + k) % 4;
      if (p[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_tag[i] = '0; m_data[i] = '0; m_valid[i] = 1'b0;
    end
    m_last = 3;
  endtask

  task automatic model_fill(input int s, input logic [AW-1:0] a, input logic [31:0] d);
    m_tag[s]   = a;
    m_data[s]  = d;
    m_valid[s] = !downloading;
    m_last     = s;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; slot_cs = '0; sdram_ack = 1'b0; data_rdy = 1'b0;
    downloading = 1'b0; loop_rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Play the SDRAM controller for one read: wait for the request, hold ack
  // off for ack_dly cycles, then return data data_dly cycles after ack (or
  // with the ack when same is set). Returns at the negedge one cycle after
  // data_rdy. lat is the number of cycles until sdram_req was seen.
  task automatic serve(input logic [AW-1:0] exp_addr, input int ack_dly,
                       input int data_dly, input logic [31:0] d, input bit same,
                       input int chg_slot, input logic [AW-1:0] chg_addr,
                       output int lat);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sdram_req && n < 20);
    lat = n;
    checks++;
    if (sdram_req !== 1'b1) begin
      errors++;
      $display("FAIL req_timeout: sdram_req=%b after %0d cycles, wanted 1", sdram_req, n);
      return;
    end
    checks++;
    if (sdram_addr !== exp_addr) begin
      errors++;
      $display("FAIL grant_addr: got %h expected %h", sdram_addr, exp_addr);
    end
    repeat (ack_dly) begin
      @(negedge clk);
      checks++;
      if (sdram_req !== 1'b1 || sdram_addr !== exp_addr) begin
        errors++;
        $display("FAIL req_hold: req=%b addr=%h expected req=1 addr=%h",
                 sdram_req, sdram_addr, exp_addr);
      end
    end
    sdram_ack = 1'b1;
    if (same) begin
      data_rdy = 1'b1; data_read = d;
    end
    if (chg_slot >= 0) set_addr(chg_slot, chg_addr);
    @(negedge clk);
    sdram_ack = 1'b0;
    if (same) begin
      data_rdy = 1'b0; data_read = $urandom;
    end else begin
      checks++;
      if (sdram_req !== 1'b0) begin
        errors++;
        $display("FAIL req_clear: sdram_req=%b after ack, expected 0", sdram_req);
      end
      repeat (data_dly - 1) @(negedge clk);
      data_rdy = 1'b1; data_read = d;
      @(negedge clk);
      data_rdy = 1'b0; data_read = $urandom;
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (slot_ok !== 4'b0000 || slot_dout !== '0) begin
      errors++;
      $display("FAIL reset_slots: ok=%b dout=%h expected 0", slot_ok, slot_dout);
    end
    checks++;
    if (refresh_en !== 1'b1 || sdram_req !== 1'b0 || sdram_addr !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: refresh=%b req=%b addr=%h expected 1/0/0",
               refresh_en, sdram_req, sdram_addr);
    end
  endtask

  task automatic test_loop_rst();
    int lat;
    @(negedge clk);
    loop_rst = 1'b1; slot_cs = 4'b0001; set_addr(0, 22'h00abc);
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (sdram_req !== 1'b0) begin
        errors++;
        $display("FAIL loop_rst_block: sdram_req=%b expected 0", sdram_req);
      end
    end
    loop_rst = 1'b0;
    serve(22'h00abc, 0, 1, 32'h0bad_f00d, 1'b0, -1, '0, lat);
    model_fill(0, 22'h00abc, 32'h0bad_f00d);
    slot_cs = 4'b0000;
  endtask

  task automatic test_single_miss();
    int lat;
    do_reset();
    slot_cs = 4'b0001; set_addr(0, 22'h01000);
    serve(22'h01000, 2, 3, 32'hDEADBEEF, 1'b0, -1, '0, lat);
    model_fill(0, 22'h01000, 32'hDEADBEEF);
    checks++;
    if (lat != 1) begin
      errors++;
      $display("FAIL req_latency: got %0d cycles expected 1", lat);
    end
    checks++;
    if (slot_ok !== exp_ok() || slot_dout[31:0] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_fill: ok=%b dout0=%h expected ok=%b dout0=deadbeef",
               slot_ok, slot_dout[31:0], exp_ok());
    end
  endtask

  task automatic test_round_robin();
    int lat;
    do_reset();
    for (int i = 0; i < 4; i++) set_addr(i, AW'(22'h100 + i));
    slot_cs = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      logic [31:0] d;
      d = $urandom;
      serve(a_of(k), 1, 1, d, 1'b0, -1, '0, lat);
      model_fill(k, a_of(k), d);
    end
    checks++;
    if (slot_ok !== 4'b1111 || slot_dout !== {m_data[3], m_data[2], m_data[1], m_data[0]}) begin
      errors++;
      $display("FAIL rr_all_filled: ok=%b dout=%h", slot_ok, slot_dout);
    end
    set_addr(0, 22'h500); set_addr(2, 22'h600);
    serve(22'h500, 0, 2, 32'h5050_5050, 1'b0, -1, '0, lat);
    model_fill(0, 22'h500, 32'h5050_5050);
    serve(22'h600, 0, 1, 32'h6060_6060, 1'b0, -1, '0, lat);
    model_fill(2, 22'h600, 32'h6060_6060);
    checks++;
    if (slot_ok !== exp_ok()) begin
      errors++;
      $display("FAIL rr_wrap: ok=%b expected %b", slot_ok, exp_ok());
    end
    slot_cs = 4'b0000;
  endtask

  task automatic test_addr_change();
    int lat;
    @(negedge clk);
    slot_cs = 4'b0010; set_addr(1, 22'h200);
    serve(22'h200, 1, 2, 32'h2222_0000, 1'b0, 1, 22'h204, lat);
    model_fill(1, 22'h200, 32'h2222_0000);
    checks++;
    if (slot_ok[1] !== 1'b0 || slot_dout[63:32] !== 32'h2222_0000) begin
      errors++;
      $display("FAIL moved_slot: ok1=%b dout1=%h expected 0/22220000",
               slot_ok[1], slot_dout[63:32]);
    end
    serve(22'h204, 0, 1, 32'h2222_0004, 1'b0, -1, '0, lat);
    model_fill(1, 22'h204, 32'h2222_0004);
    checks++;
    if (slot_ok !== exp_ok() || slot_dout[63:32] !== 32'h2222_0004) begin
      errors++;
      $display("FAIL refetch: ok=%b dout1=%h expected ok=%b dout1=22220004",
               slot_ok, slot_dout[63:32], exp_ok());
    end
    slot_cs = 4'b0000;
  endtask

  task automatic test_download();
    int lat;
    @(negedge clk);
    for (int i = 0; i < 4; i++) set_addr(i, AW'(22'h40 + i));
    slot_cs = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      int s;
      logic [31:0] d;
      s = rr_next(exp_pend());
      d = $urandom;
      serve(a_of(s), 0, 1, d, 1'b0, -1, '0, lat);
      model_fill(s, a_of(s), d);
    end
    checks++;
    if (slot_ok !== 4'b1111) begin
      errors++;
      $display("FAIL dl_prefill: ok=%b expected 1111", slot_ok);
    end
    downloading = 1'b1;
    for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (slot_ok !== exp_ok() || sdram_req !== 1'b0 || refresh_en !== 1'b0) begin
        errors++;
        $display("FAIL dl_block: ok=%b req=%b refresh=%b expected %b/0/0",
                 slot_ok, sdram_req, refresh_en, exp_ok());
      end
    end
    slot_cs = 4'b0000;
    downloading = 1'b0;
    @(negedge clk);
    checks++;
    if (refresh_en !== 1'b1 || sdram_req !== 1'b0) begin
      errors++;
      $display("FAIL dl_release: refresh=%b req=%b expected 1/0", refresh_en, sdram_req);
    end
  endtask

  task automatic test_ack_with_data();
    int lat;
    @(negedge clk);
    slot_cs = 4'b0100; set_addr(2, 22'h777);
    serve(22'h777, 1, 1, 32'h7777_ABCD, 1'b1, -1, '0, lat);
    model_fill(2, 22'h777, 32'h7777_ABCD);
    checks++;
    if (refresh_en !== 1'b1 || slot_ok !== exp_ok() || slot_dout[95:64] !== 32'h7777_ABCD) begin
      errors++;
      $display("FAIL ack_data_same: refresh=%b ok=%b dout2=%h expected 1/%b/7777abcd",
               refresh_en, slot_ok, slot_dout[95:64], exp_ok());
    end
    slot_cs = 4'b0000;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    @(negedge clk);
    slot_cs = 4'b0001; set_addr(0, 22'h3000);
    do begin
      @(negedge clk);
      n++;
    end while (!sdram_req && n < 20);
    checks++;
    if (sdram_req !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_req: sdram_req=%b expected 1", sdram_req);
    end
    sdram_ack = 1'b1;
    @(negedge clk);
    sdram_ack = 1'b0;
    rst = 1'b1; slot_cs = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    checks++;
    if (sdram_req !== 1'b0 || sdram_addr !== '0 || slot_dout !== '0) begin
      errors++;
      $display("FAIL rst_mid_abort: req=%b addr=%h dout=%h expected all 0",
               sdram_req, sdram_addr, slot_dout);
    end
    data_rdy = 1'b1; data_read = 32'h1234_5678;
    @(negedge clk);
    data_rdy = 1'b0;
    slot_cs = 4'b1111; set_addr(0, 22'h3000); set_addr(2, 22'h777);
    #1;
    checks++;
    if (slot_dout !== '0 || slot_ok !== exp_ok()) begin
      errors++;
      $display("FAIL rst_mid_late_data: ok=%b dout=%h expected ok=%b dout=0",
               slot_ok, slot_dout, exp_ok());
    end
    slot_cs = 4'b0000;
  endtask

  task automatic test_random();
    int lat;
    do_reset();
    for (int it = 0; it < 60; it++) begin
      logic [3:0] p;
      slot_cs = 4'($urandom);
      for (int i = 0; i < 4; i++) set_addr(i, AW'(i * 16 + $urandom_range(0, 2)));
      #1;
      p = exp_pend();
      checks++;
      if (slot_ok !== exp_ok() || refresh_en !== (p == 4'b0) ||
          slot_dout !== {m_data[3], m_data[2], m_data[1], m_data[0]}) begin
        errors++;
        $display("FAIL rand_state it=%0d: ok=%b refresh=%b dout=%h expected ok=%b refresh=%b dout=%h",
                 it, slot_ok, refresh_en, slot_dout, exp_ok(), (p == 4'b0),
                 {m_data[3], m_data[2], m_data[1], m_data[0]});
      end
      if (p != 4'b0) begin
        int s;
        logic [AW-1:0] a;
        logic [31:0]   d;
        s = rr_next(p);
        a = a_of(s);
        d = $urandom;
        serve(a, $urandom_range(0, 3), $urandom_range(1, 3), d,
              ($urandom_range(0, 3) == 0), -1, '0, lat);
        model_fill(s, a, d);
      end else begin
        @(negedge clk);
        checks++;
        if (sdram_req !== 1'b0) begin
          errors++;
          $display("FAIL rand_idle it=%0d: sdram_req=%b expected 0", it, sdram_req);
        end
      end
    end
    slot_cs = 4'b0000;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_loop_rst();
    test_single_miss();
    test_round_robin();
    test_addr_change();
    test_download();
    test_ack_with_data();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtframe_slot_arb.md
JTFRAME_SLOT_ARB -- requirements
Module: jtframe_slot_arb

Interface
REQ-001 The module SHALL have parameter AW, default 22, giving the SDRAM word-address width.
REQ-002 The module SHALL have port clk, input, 1 bit: the single system clock (SDRAM clock domain).
REQ-003 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port downloading, input, 1 bit: ROM download in progress; blocks new grants.
REQ-005 The module SHALL have port loop_rst, input, 1 bit: SDRAM init loop active; blocks new grants.
REQ-006 The module SHALL have port slot_cs, input, 4 bits: per-slot read request, slot i = bit i.
REQ-007 The module SHALL have port slot_addr, input, 4*AW bits: per-slot absolute word address, slot i = bits [i*AW +: AW].
REQ-008 The module SHALL have port slot_ok, output, 4 bits: slot data valid for the current address.
REQ-009 The module SHALL have port slot_dout, output, 128 bits: per-slot 32-bit cached word, slot i = bits [i*32 +: 32].
REQ-010 The module SHALL have port sdram_req, output, 1 bit: SDRAM read request.
REQ-011 The module SHALL have port sdram_ack, input, 1 bit: SDRAM controller accepted the request.
REQ-012 The module SHALL have port sdram_addr, output, AW bits: SDRAM read address.
REQ-013 The module SHALL have port data_rdy, input, 1 bit: data_read is valid this cycle.
REQ-014 The module SHALL have port data_read, input, 32 bits: SDRAM read data.
REQ-015 The module SHALL have port refresh_en, output, 1 bit: SDRAM refresh allowed.

Function
REQ-016 Each slot SHALL own a one-entry cache holding tag[i] (AW bits), data[i] (32 bits) and valid[i].
REQ-017 hit[i] SHALL be combinational: slot_cs[i] & valid[i] & (slot_addr[i] == tag[i]); slot_ok[i] = hit[i].
REQ-018 slot_dout[i] SHALL always equal data[i], whatever the state of slot_ok[i].
REQ-019 pend[i] SHALL be slot_cs[i] & ~hit[i].
REQ-020 The FSM SHALL have three states: IDLE, WAIT_ACK, WAIT_DATA.
REQ-021 In IDLE, when |pend is set and downloading, loop_rst are both low, the FSM SHALL grant the first pending slot in round-robin order starting at last_grant+1 (mod 4).
REQ-022 On a grant the FSM SHALL latch the grant index g and the address A, drive sdram_addr=A and sdram_req=1, and move to WAIT_ACK.
REQ-023 The FSM SHALL hold sdram_req=1 and sdram_addr stable in WAIT_ACK until sdram_ack=1, then clear sdram_req on the next clock edge and move to WAIT_DATA.
REQ-024 In WAIT_DATA, on data_rdy=1 the FSM SHALL write tag[g]=A, data[g]=data_read and valid[g]=1, set last_grant=g, and return to IDLE.
REQ-025 If sdram_ack and data_rdy are both high in WAIT_ACK, the FSM SHALL treat it as completion per REQ-024 and go to IDLE.
REQ-026 Latency SHALL be as follows: pend in IDLE gives sdram_req on the next cycle; data_rdy gives slot_ok high on the next cycle if the slot address still equals A.
REQ-027 If the slot address changes during a transaction, the fill SHALL still be stored under tag A; slot_ok stays low and the slot re-requests.
REQ-028 If slot_cs drops during a transaction, the transaction SHALL complete and the cache SHALL be filled; it is never abandoned.
REQ-029 While downloading=1, all valid bits SHALL be cleared every cycle; a transaction in flight completes its handshake, but its fill does not set valid.
REQ-030 refresh_en SHALL be (state==IDLE) & ~|pend.
REQ-031 There SHALL be no timeout; the FSM waits indefinitely for sdram_ack or data_rdy.

Reset
REQ-032 On rst: state=IDLE, sdram_req=0, sdram_addr=0, valid=0000, tag=0, data=0, last_grant=3 (so slot 0 is served first).
REQ-033 On rst mid-transaction: the FSM SHALL abort immediately to IDLE and any later data_rdy SHALL be ignored.
REQ-034 Outputs after reset SHALL be: slot_ok=0, slot_dout=0, refresh_en=1 when slot_cs=0.

Structure
REQ-035 The FSM state encoding and slot count (4) SHALL be defined in a shared package jtframe_slot_pkg.
REQ-036 The per-slot cache (tag/data/valid plus hit compare) SHALL be one sub-module, jtframe_slot_cache, instantiated 4 times.
REQ-037 The round-robin selection SHALL be a function in the package, not a separate module.

Verification
REQ-038 Single miss: slot_cs=0001, addr0=0x01000, ack after 2 cycles, data_rdy 3 cycles later with 0xDEADBEEF -> sdram_addr=0x01000; slot_ok[0]=1 and slot_dout[0]=0xDEADBEEF one cycle after data_rdy.
REQ-039 Round robin: slot_cs=1111 with all slots missing -> grant order 0,1,2,3; then with slot 0 missing again after slot 3 is served -> next grant is 0.
REQ-040 Address change mid-flight: slot 1 addr 0x200 is granted, then changes to 0x204 before data_rdy -> slot_ok[1]=0 and a second request is issued to 0x204.
REQ-041 Download: valid=1111, downloading pulses high -> slot_ok=0000; no sdram_req while downloading=1.
REQ-042 ack together with data_rdy in the same cycle -> fill completes; FSM is in IDLE on the next cycle; refresh_en=1 if no slot is pending.
REQ-043 rst asserted in WAIT_DATA -> sdram_req=0 and valid=0000; a data_rdy arriving afterwards leaves all caches unchanged.
